// File: rtl/instr_seq.sv
// instr_seq: multi-cycle MSP430 instruction sequencer driving datapath selects and strobes.
// The IR and state are registered; strobes that depend on the memory handshake are decoded from state and mem_rdy.
module instr_seq #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rdy,
  input  logic [SIZE-1:0] MDB_out,
  input  logic [3:0]      CVNZ,
  output logic [SIZE-1:0] ir,
  output logic [2:0]      MAB_SEL,
  output logic [2:0]      MPC,
  output logic            MW,
  output logic            RW,
  output logic            sr_we,
  output logic            rs_inc,
  output logic            sp_dec,
  output logic            illegal,
  output logic [3:0]      state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, EXEC, DST_WR, PUSH
  } state_t;
  state_t state_q, state_d, src_st, post_src;
  logic [SIZE-1:0] ir_q, ir_d;
  logic is_jmp, is_f1, is_f2, bad, cg, imm, ad, dst_mem, f1_mov, f1_nowr, f2_push, f2_flags, to_wr, taken, nv;
  logic [1:0] as_m;
  logic [2:0] f2op;
  logic [3:0] rsrc;
  logic [7:0] conds;
  assign is_jmp   = ir_q[15:13] == 3'b001;
  assign is_f2    = ir_q[15:10] == 6'b000100;
  assign is_f1    = ir_q[15:12] >= 4'd4;
  assign f2op     = ir_q[9:7];
  assign bad      = !(is_jmp || is_f1 || is_f2) || (is_f2 && f2op[2:1] == 2'b11);
  assign as_m     = ir_q[5:4];
  assign ad       = ir_q[7];
  assign rsrc     = is_f1 ? ir_q[11:8] : ir_q[3:0];
  assign cg       = rsrc == 4'd3 || (rsrc == 4'd2 && as_m[1]);
  assign imm      = as_m == 2'b11 && rsrc == 4'd0;
  assign f1_mov   = ir_q[15:12] == 4'h4;
  assign f1_nowr  = ir_q[15:12] == 4'h9 || ir_q[15:12] == 4'hB;
  assign f2_push  = f2op[2];
  assign f2_flags = f2op != 3'b001;
  // constant-generator operands behave like registers: no memory read, no memory write-back
  assign dst_mem  = as_m != 2'b00 && !cg;
  assign to_wr    = (is_f1 && ad && !f1_nowr) || (is_f2 && !f2_push && dst_mem);
  assign post_src = is_f1 ? (ad ? DST_EXT : EXEC) : (f2_push ? PUSH : EXEC);
  assign src_st   = (cg || as_m == 2'b00) ? post_src : (as_m == 2'b01 || imm) ? SRC_EXT : SRC_RD;
  assign nv       = CVNZ[2] ^ CVNZ[3];
  assign conds    = {1'b1, nv, ~nv, CVNZ[2], CVNZ[0], ~CVNZ[0], CVNZ[1], ~CVNZ[1]};
  assign taken    = conds[ir_q[12:10]];
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    case (state_q)
      FETCH:   begin
        state_d = mem_rdy ? DECODE : FETCH;
        ir_d = mem_rdy ? MDB_out : ir_q;
      end
      DECODE:  state_d = bad ? FETCH : is_jmp ? EXEC : src_st;
      SRC_EXT: state_d = !mem_rdy ? SRC_EXT : imm ? post_src : SRC_RD;
      SRC_RD:  state_d = mem_rdy ? post_src : SRC_RD;
      DST_EXT: state_d = !mem_rdy ? DST_EXT : f1_mov ? EXEC : DST_RD;
      DST_RD:  state_d = mem_rdy ? EXEC : DST_RD;
      EXEC:    state_d = to_wr ? DST_WR : FETCH;
      DST_WR:  state_d = mem_rdy ? FETCH : DST_WR;
      PUSH:    state_d = !mem_rdy ? PUSH : f2op[0] ? EXEC : FETCH;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  // strobes are forced low while reset is held so an abandoned instruction issues nothing
  always_comb begin
    MAB_SEL = 3'b000;
    MPC = 3'b000;
    MW = 1'b0;
    RW = 1'b0;
    sr_we = 1'b0;
    rs_inc = 1'b0;
    sp_dec = 1'b0;
    illegal = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH, SRC_EXT, DST_EXT: MPC = mem_rdy ? 3'b001 : 3'b000;
        DECODE: illegal = bad;
        SRC_RD: begin
          MAB_SEL = as_m == 2'b01 ? 3'b010 : 3'b001;
          rs_inc = mem_rdy && as_m == 2'b11;
        end
        DST_RD: MAB_SEL = 3'b010;
        EXEC: begin
          MPC = ((is_jmp && taken) || (is_f2 && f2_push)) ? 3'b010 : 3'b000;
          RW = (is_f1 && !ad && !f1_nowr) || (is_f2 && !f2_push && !dst_mem);
          sr_we = (is_f1 && !f1_mov) || (is_f2 && !f2_push && f2_flags);
        end
        DST_WR: begin
          MAB_SEL = (is_f1 || as_m == 2'b01) ? 3'b010 : 3'b001;
          MW = mem_rdy;
        end
        PUSH: begin
          MAB_SEL = 3'b011;
          MW = mem_rdy;
          sp_dec = mem_rdy;
        end
        default: ;
      endcase
    end
  end
  assign ir = ir_q;
  assign state = state_q;
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: random and directed instructions checked cycle by cycle against a phase-list model.
module tb_instr_seq;
  localparam int FETCH = 0, DECODE = 1, SRC_EXT = 2, SRC_RD = 3, DST_EXT = 4, DST_RD = 5, EXEC = 6, DST_WR = 7, PUSH = 8;
  typedef struct packed {
    logic [3:0] st;
    logic       mem;
    logic [2:0] mab;
    logic [2:0] mpc;
    logic       mw, rw, srwe, rsinc, spdec, ill;
  } step_t;
  logic clk = 1'b0, rst = 1'b0, mem_rdy = 1'b0;
  logic [15:0] MDB_out = '0;
  logic [3:0] CVNZ = '0;
  logic [15:0] ir;
  logic [2:0] MAB_SEL, MPC;
  logic MW, RW, sr_we, rs_inc, sp_dec, illegal;
  logic [3:0] state;
  int n_tests = 0, n_fail = 0;
  step_t plan[$];
  instr_seq #(.SIZE(16)) dut (
    .clk(clk), .rst(rst), .mem_rdy(mem_rdy), .MDB_out(MDB_out), .CVNZ(CVNZ),
    .ir(ir), .MAB_SEL(MAB_SEL), .MPC(MPC), .MW(MW), .RW(RW), .sr_we(sr_we),
    .rs_inc(rs_inc), .sp_dec(sp_dec), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic add(input int st, input bit mem, input int mab, input int mpc, input bit mw, input bit rw,
                     input bit srwe, input bit rsinc, input bit spdec, input bit ill);
    step_t s;
    s.st = 4'(st);
    s.mem = mem;
    s.mab = 3'(mab);
    s.mpc = 3'(mpc);
    s.mw = mw;
    s.rw = rw;
    s.srwe = srwe;
    s.rsinc = rsinc;
    s.spdec = spdec;
    s.ill = ill;
    plan.push_back(s);
  endtask
  // expected phase list of one instruction, straight from the decode and addressing-mode rules
  task automatic build(input logic [15:0] w, input logic [3:0] f);
    int hi, op, as_m, rs, cc;
    bit ad, cg, taken, regdst, c, z, n, v;
    plan.delete();
    hi = int'(w) >> 12;
    op = (int'(w) >> 7) % 8;
    as_m = (int'(w) >> 4) % 4;
    cc = (int'(w) >> 10) % 8;
    ad = w[7];
    c = f[0]; z = f[1]; n = f[2]; v = f[3];
    add(FETCH, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    if (hi == 2 || hi == 3) begin
      add(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (cc)
        0: taken = !z;
        1: taken = z;
        2: taken = !c;
        3: taken = c;
        4: taken = n;
        5: taken = n == v;
        6: taken = n != v;
        default: taken = 1;
      endcase
      add(EXEC, 0, 0, taken ? 2 : 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    if (hi < 4 && !((int'(w) >> 10) == 4 && op < 6)) begin
      add(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      return;
    end
    add(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs = hi >= 4 ? (int'(w) >> 8) % 16 : int'(w) % 16;
    cg = rs == 3 || (rs == 2 && as_m >= 2);
    if (!cg) begin
      if (as_m == 1) begin
        add(SRC_EXT, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(SRC_RD, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      end else if (as_m == 2) add(SRC_RD, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      else if (as_m == 3 && rs == 0) add(SRC_EXT, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      else if (as_m == 3) add(SRC_RD, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    if (hi >= 4) begin
      if (ad) begin
        add(DST_EXT, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        if (hi != 4) add(DST_RD, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        add(EXEC, 0, 0, 0, 0, 0, hi != 4, 0, 0, 0);
        if (hi != 9 && hi != 11) add(DST_WR, 1, 2, 0, 1, 0, 0, 0, 0, 0);
      end else add(EXEC, 0, 0, 0, 0, hi != 9 && hi != 11, hi != 4, 0, 0, 0);
    end else if (op >= 4) begin
      add(PUSH, 1, 3, 0, 1, 0, 0, 0, 1, 0);
      if (op == 5) add(EXEC, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    end else begin
      regdst = as_m == 0 || cg;
      add(EXEC, 0, 0, 0, 0, regdst, op != 1, 0, 0, 0);
      if (!regdst) add(DST_WR, 1, as_m == 1 ? 2 : 1, 0, 1, 0, 0, 0, 0, 0);
    end
  endtask
  // mode 0: zero-wait memory, 1: random waits (at most 3), 2: exactly 3 wait cycles per access
  task automatic run_instr(input logic [15:0] w, input logic [3:0] f, input int mode, input int abort_st);
    step_t s;
    int waits;
    bit g;
    logic [11:0] e;
    build(w, f);
    CVNZ = f;
    waits = 0;
    while (plan.size() > 0) begin
      s = plan[0];
      @(negedge clk);
      if (int'(s.st) == abort_st) return;
      mem_rdy = !s.mem ? 1'($urandom_range(0, 1)) :
                (mode == 0 || waits >= 3 || (mode == 1 && $urandom_range(0, 1) == 1));
      MDB_out = int'(s.st) == FETCH ? w : 16'($urandom);
      #1;
      g = s.mem && !mem_rdy;
      e = {s.mab, g ? 3'b000 : s.mpc, s.mw & !g, s.rw, s.srwe, s.rsinc & !g, s.spdec & !g, s.ill};
      check($sformatf("state w=%h", w), 32'(state), 32'(s.st));
      check($sformatf("outs w=%h st=%0d", w, s.st), 32'({MAB_SEL, MPC, MW, RW, sr_we, rs_inc, sp_dec, illegal}), 32'(e));
      if (int'(s.st) == DECODE) check($sformatf("ir w=%h", w), 32'(ir), 32'(w));
      if (!s.mem || mem_rdy) begin
        void'(plan.pop_front());
        waits = 0;
      end else waits++;
    end
  endtask
  function automatic logic [15:0] rand_word();
    logic [15:0] x;
    int k;
    x = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k < 2) x[15:13] = 3'b001;
    else if (k < 5) x[15:10] = 6'b000100;
    else if (k == 5) x[15:12] = 4'($urandom_range(0, 3));
    return x;
  endfunction
  initial begin
    #1;
    check("reset state", 32'(state), FETCH);
    check("reset ir", 32'(ir), 0);
    mem_rdy = 1'b1;
    #1;
    check("reset outs", 32'({MAB_SEL, MPC, MW, RW, sr_we, rs_inc, sp_dec, illegal}), 0);
    mem_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_instr(16'h4405, 4'h0, 0, -1);
    run_instr(16'h5035, 4'h0, 0, -1);
    run_instr(16'h2405, 4'b0010, 0, -1);
    run_instr(16'h2405, 4'b0000, 0, -1);
    run_instr(16'h3C05, 4'h0, 0, -1);
    run_instr(16'h3C05, 4'hF, 1, -1);
    run_instr(16'h1206, 4'h0, 2, -1);
    run_instr(16'h0000, 4'h0, 0, -1);
    run_instr(16'h9295, 4'h0, 1, -1);
    run_instr(16'h12B0, 4'h0, 1, -1);
    run_instr(16'h1025, 4'h0, 1, -1);
    run_instr(16'h1095, 4'h0, 2, -1);
    run_instr(16'h1305, 4'h0, 0, -1);
    run_instr(16'h45B6, 4'h0, 1, -1);
    run_instr(16'h4335, 4'h0, 0, -1);
    for (int i = 0; i < 400; i++) run_instr(rand_word(), 4'($urandom), $urandom_range(0, 2), -1);
    run_instr(16'h5295, 4'h0, 0, DST_RD);
    mem_rdy = 1'b0;
    check("pre-reset state", 32'(state), DST_RD);
    #2;
    rst = 1'b0;
    #1;
    check("async reset state", 32'(state), FETCH);
    check("async reset ir", 32'(ir), 0);
    mem_rdy = 1'b1;
    #1;
    check("async reset outs", 32'({MAB_SEL, MPC, MW, RW, sr_we, rs_inc, sp_dec, illegal}), 0);
    @(posedge clk);
    #1;
    check("held reset state", 32'(state), FETCH);
    check("held reset outs", 32'({MAB_SEL, MPC, MW, RW, sr_we, rs_inc, sp_dec, illegal}), 0);
    mem_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_instr(16'h4405, 4'h0, 0, -1);
    run_instr(16'h5295, 4'h0, 1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
